// File: rtl/systolic_pkg.sv
// Shared types for the systolic array edge blocks: element, row vector and
// the row-FIFO entry carried by the result drain.
package systolic_pkg;

    localparam int unsigned DEF_DIM    = 8;
    localparam int unsigned DEF_BITS_C = 64;

    typedef logic signed [DEF_BITS_C-1:0] elem_t;
    typedef elem_t [DEF_DIM-1:0]           row_t;
    typedef logic [$clog2(DEF_DIM)-1:0]    row_idx_t;

    typedef struct packed {
        row_t     data;
        row_idx_t row;
        logic     last;
    } fifo_entry_t;

endpackage

// File: rtl/deskew_lane.sv
// Fixed-length delay line for one result lane; STAGES=0 degenerates to a wire.
module deskew_lane #(
    parameter int unsigned BITS_C = 64,
    parameter int unsigned STAGES = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [BITS_C-1:0] i_data,
    output logic [BITS_C-1:0] o_data
);

    if (STAGES == 0) begin : g_pass
        logic w_unused;
        assign w_unused = clk ^ rst;
        assign o_data   = i_data;
    end else begin : g_pipe
        logic [STAGES-1:0][BITS_C-1:0] r_pipe;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_pipe <= '0;
            end else begin
                r_pipe[0] <= i_data;
                for (int k = 1; k < STAGES; k++) begin
                    r_pipe[k] <= r_pipe[k-1];
                end
            end
        end

        assign o_data = r_pipe[STAGES-1];
    end

endmodule

// File: rtl/result_deskew_drain.sv
// Realigns skewed result lanes from the array bottom edge into whole rows and
// buffers them in a small row FIFO with tile-relative row tags.
module result_deskew_drain
    import systolic_pkg::*;
#(
    parameter int unsigned BITS_C = DEF_BITS_C,
    parameter int unsigned DIM    = DEF_DIM,
    parameter int unsigned DEPTH  = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           flush,
    input  logic                           in_valid,
    input  logic signed [DIM-1:0][BITS_C-1:0] Cin,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic signed [DIM-1:0][BITS_C-1:0] Cout,
    output logic [$clog2(DIM)-1:0]         Crow,
    output logic                           Clast,
    output logic                           overflow,
    output logic [$clog2(DEPTH):0]         count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned IDX_W = $clog2(DIM);

    // The FIFO entry type is fixed by the shared package geometry.
    if (DIM != DEF_DIM || BITS_C != DEF_BITS_C) begin : g_param_check
        $error("result_deskew_drain: DIM/BITS_C must match systolic_pkg");
    end

    logic [DIM-1:0][BITS_C-1:0] w_aligned;
    logic                       w_row_valid;
    logic [DIM-2:0]             r_vpipe;

    for (genvar i = 0; i < DIM; i++) begin : g_lane
        deskew_lane #(
            .BITS_C (BITS_C),
            .STAGES (DIM - 1 - i)
        ) u_lane (
            .clk    (clk),
            .rst    (rst),
            .i_data (Cin[i]),
            .o_data (w_aligned[i])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vpipe <= '0;
        end else if (flush) begin
            r_vpipe <= '0;
        end else begin
            r_vpipe[0] <= in_valid;
            for (int k = 1; k < DIM - 1; k++) begin
                r_vpipe[k] <= r_vpipe[k-1];
            end
        end
    end

    assign w_row_valid = r_vpipe[DIM-2];

    fifo_entry_t        r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wptr;
    logic [PTR_W-1:0]   r_rptr;
    logic [CNT_W-1:0]   r_count;
    row_idx_t           r_idx;
    logic               r_overflow;

    logic               w_valid;
    logic               w_full;
    logic               w_pop;
    logic               w_push;
    logic               w_drop;
    fifo_entry_t        w_entry;
    fifo_entry_t        w_head;

    assign w_valid = (r_count != '0);
    assign w_full  = (r_count == CNT_W'(DEPTH));
    assign w_pop   = w_valid & out_ready;
    // A full FIFO still accepts a row when the head leaves in the same cycle.
    assign w_push  = w_row_valid & (~w_full | w_pop);
    assign w_drop  = w_row_valid & ~w_push;

    always_comb begin
        w_entry      = '0;
        w_entry.data = w_aligned;
        w_entry.row  = r_idx;
        w_entry.last = (r_idx == IDX_W'(DIM - 1));
    end

    always_ff @(posedge clk) begin
        if (w_push && !flush) begin
            r_mem[r_wptr] <= w_entry;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_idx      <= '0;
            r_overflow <= 1'b0;
        end else if (flush) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_idx      <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CNT_W'(1);
            end
            // Dropped rows still advance the tag so tile framing survives overflow.
            if (w_row_valid) begin
                r_idx <= r_idx + IDX_W'(1);
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    always_comb begin
        w_head    = r_mem[r_rptr];
        out_valid = w_valid;
        Cout      = '0;
        Crow      = '0;
        Clast     = 1'b0;
        if (w_valid) begin
            Cout  = w_head.data;
            Crow  = w_head.row;
            Clast = w_head.last;
        end
        overflow  = r_overflow;
        count     = r_count;
    end

endmodule

// File: tb/tb_result_deskew_drain.sv
// Scoreboard bench for result_deskew_drain: skewed row stimulus, expected rows
// queued at issue time and checked by an independent output monitor.
module tb_result_deskew_drain;

    localparam int DIM    = 8;
    localparam int DEPTH  = 8;
    localparam int BITS_C = 64;

    logic                       clk = 1'b0;
    logic                       rst;
    logic                       flush;
    logic                       in_valid;
    logic [DIM-1:0][BITS_C-1:0] Cin;
    logic                       out_valid;
    logic                       out_ready;
    logic [DIM-1:0][BITS_C-1:0] Cout;
    logic [2:0]                 Crow;
    logic                       Clast;
    logic                       overflow;
    logic [3:0]                 count;

    typedef struct {
        logic [511:0] data;
        logic [2:0]   row;
        logic         last;
    } exp_t;

    exp_t        exp_q[$];
    logic [63:0] stim [16][8];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          n_pops = 0;
    int          first_pop = 0;
    int          last_pop = 0;
    int          max_count = 0;
    int          send_t0 = 0;

    result_deskew_drain #(
        .BITS_C (BITS_C),
        .DIM    (DIM),
        .DEPTH  (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .Cin       (Cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Cout      (Cout),
        .Crow      (Crow),
        .Clast     (Clast),
        .overflow  (overflow),
        .count     (count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [511:0] got, input logic [511:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT hands over a row.
    always @(negedge clk) begin
        exp_t e;
        if (int'(count) > max_count) max_count = int'(count);
        if (!rst && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_row: got row %0d data %0h expected none", Crow, Cout);
            end else begin
                e = exp_q.pop_front();
                if (Cout !== e.data || Crow !== e.row || Clast !== e.last) begin
                    errors++;
                    $display("FAIL row_pop: got data %0h row %0d last %0b expected data %0h row %0d last %0b",
                             Cout, Crow, Clast, e.data, e.row, e.last);
                end
            end
            if (n_pops == 0) first_pop = cyc;
            last_pop = cyc;
            n_pops++;
        end
    end

    task automatic push_exp(input int r, input int crow);
        exp_t e;
        for (int i = 0; i < DIM; i++) e.data[i*64 +: 64] = stim[r][i];
        e.row  = 3'(crow);
        e.last = (crow == DIM - 1);
        exp_q.push_back(e);
    endtask

    // Drives n rows from stim[base..] with lane i lagging lane 0 by i cycles.
    task automatic send(input int base, input int n, input int ready_at);
        for (int c = 0; c < n + DIM - 1; c++) begin
            @(posedge clk);
            #1;
            if (c == 0) send_t0 = cyc;
            in_valid = (c < n);
            for (int i = 0; i < DIM; i++) begin
                if (c - i >= 0 && c - i < n) Cin[i] = stim[base + c - i][i];
                else Cin[i] = 64'hDEAD_BEEF_0000_0000 | 64'(c);
            end
            if (c == ready_at) out_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic do_flush();
        @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        chk("flush_count", count, 0);
        chk("flush_valid", out_valid, 0);
        chk("flush_overflow", overflow, 0);
    endtask

    task automatic wait_drain(input string name);
        int k = 0;
        while (exp_q.size() != 0 && k < 200) begin
            @(posedge clk);
            k++;
        end
        @(negedge clk);
        chk({"drain_", name}, exp_q.size(), 0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        Cin       = '0;
        #12;
        chk("reset_valid", out_valid, 0);
        chk("reset_count", count, 0);
        chk("reset_overflow", overflow, 0);
        chk("reset_cout", Cout, 0);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);

        // Single row: latency DIM cycles, one pop
        for (int i = 0; i < DIM; i++) stim[0][i] = 64'(100 + i);
        out_ready = 1'b1;
        n_pops = 0;
        push_exp(0, 0);
        send(0, 1, -1);
        wait_drain("single");
        chk("single_latency", first_pop, send_t0 + 8);
        chk("single_pops", n_pops, 1);

        // Full tile back-to-back
        do_flush();
        for (int r = 0; r < DIM; r++) begin
            for (int i = 0; i < DIM; i++) stim[r][i] = 64'(r * 16 + i);
            push_exp(r, r);
        end
        n_pops = 0;
        max_count = 0;
        send(0, 8, -1);
        wait_drain("tile");
        chk("tile_first_pop", first_pop, send_t0 + 8);
        chk("tile_last_pop", last_pop, send_t0 + 15);
        chk("tile_pops", n_pops, 8);
        chk("tile_max_count", max_count <= 1, 1);

        // Backpressure and overflow: ninth row dropped
        do_flush();
        out_ready = 1'b0;
        for (int r = 0; r < 9; r++) begin
            for (int i = 0; i < DIM; i++) stim[r][i] = 64'h1000 + 64'(r * 256 + i);
            if (r < 8) push_exp(r, r);
        end
        send(0, 9, -1);
        chk("ovf_count", count, 8);
        chk("ovf_flag", overflow, 1);
        chk("ovf_valid", out_valid, 1);
        repeat (3) @(posedge clk);
        #1;
        chk("stall_cout", Cout, exp_q[0].data);
        chk("stall_crow", Crow, 0);
        chk("stall_count", count, 8);
        out_ready = 1'b1;
        wait_drain("ovf");
        chk("ovf_sticky", overflow, 1);

        // Full FIFO with push and pop in the same cycle
        do_flush();
        out_ready = 1'b0;
        for (int r = 0; r < 9; r++) begin
            for (int i = 0; i < DIM; i++) stim[r][i] = 64'h5_0000 + 64'(r * 256 + i);
            push_exp(r, r % DIM);
        end
        send(0, 8, -1);
        chk("pp_full", count, 8);
        send(8, 1, 7);
        chk("pp_count", count, 8);
        chk("pp_no_ovf", overflow, 0);
        wait_drain("pushpop");

        // Negative and extreme signed values
        do_flush();
        out_ready = 1'b1;
        for (int i = 0; i < DIM; i++)
            stim[0][i] = (i % 2 == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h8000_0000_0000_0000;
        push_exp(0, 0);
        send(0, 1, -1);
        wait_drain("signed");

        // Asynchronous reset with 3 rows buffered and 2 in the pipe
        do_flush();
        out_ready = 1'b0;
        for (int r = 0; r < 5; r++)
            for (int i = 0; i < DIM; i++) stim[r][i] = 64'h7_0000 + 64'(r * 256 + i);
        fork
            send(0, 5, -1);
            begin
                @(posedge clk);
                repeat (10) @(posedge clk);
                #3;
                chk("pre_rst_count", count, 3);
                rst = 1'b1;
                #1;
                chk("rst_valid", out_valid, 0);
                chk("rst_count", count, 0);
                chk("rst_cout", Cout, 0);
            end
        join
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        out_ready = 1'b1;
        n_pops = 0;
        repeat (20) @(posedge clk);
        chk("post_rst_pops", n_pops, 0);

        // Same scenario with flush
        out_ready = 1'b0;
        fork
            send(0, 5, -1);
            begin
                @(posedge clk);
                repeat (10) @(posedge clk);
                #3;
                chk("pre_flush_count", count, 3);
                flush = 1'b1;
                @(posedge clk);
                #3 flush = 1'b0;
                chk("mid_flush_valid", out_valid, 0);
                chk("mid_flush_count", count, 0);
                chk("mid_flush_cout", Cout, 0);
            end
        join
        out_ready = 1'b1;
        n_pops = 0;
        repeat (20) @(posedge clk);
        chk("post_flush_pops", n_pops, 0);
        for (int i = 0; i < DIM; i++) stim[0][i] = 64'h9_0000 + 64'(i);
        push_exp(0, 0);
        send(0, 1, -1);
        wait_drain("after_flush");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
